// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 codes, FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Iteration counter must hold values 0..width-1 with a spare bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return 32'($clog2(width) + 1);
  endfunction

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue / write-back bundle between the core and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned Width = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic [4:0]       rd_in;
  logic             busy;
  logic             done;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [Width-1:0] wb_data;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement negate; used both for operand magnitudes
// and for restoring the result sign after the unsigned iteration.
module muldiv_absneg #(
  parameter int unsigned Width = 32
) (
  input  logic             neg,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout_c
);
  assign dout_c = neg ? (~din + Width'(1)) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit: Width-cycle shift-add / restoring
// shift-subtract on magnitudes, one sign-fix cycle, then a one-cycle write-back.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned Width = DEF_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(Width);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           f3_q;
  logic [4:0]           rd_q;
  logic                 a_neg_q, b_neg_q, dz_q;
  logic [Width-1:0]     opnd_q;
  logic [2*Width-1:0]   acc_q;

  logic                 accept_c;
  logic                 a_neg_c, b_neg_c, sign_diff_c;
  logic [Width-1:0]     a_mag_c, b_mag_c;
  logic [Width:0]       mul_sum_c, div_shift_c, div_diff_c;
  logic [2*Width-1:0]   acc_step_c, prod_c;
  logic [Width-1:0]     quo_c, rem_c, result_c;
  logic                 busy_d, done_d, wb_en_d, wb_load_c;

  assign a_neg_c     = signed_a(bus.funct3) & bus.op_a[Width-1];
  assign b_neg_c     = signed_b(bus.funct3) & bus.op_b[Width-1];
  assign sign_diff_c = a_neg_q ^ b_neg_q;
  assign accept_c    = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.flush;

  muldiv_absneg #(.Width(Width)) u_abs_a (.neg(a_neg_c), .din(bus.op_a), .dout_c(a_mag_c));
  muldiv_absneg #(.Width(Width)) u_abs_b (.neg(b_neg_c), .din(bus.op_b), .dout_c(b_mag_c));

  muldiv_absneg #(.Width(2*Width)) u_fix_prod (
    .neg(sign_diff_c), .din(acc_q), .dout_c(prod_c)
  );
  muldiv_absneg #(.Width(Width)) u_fix_quo (
    .neg(sign_diff_c), .din(acc_q[Width-1:0]), .dout_c(quo_c)
  );
  muldiv_absneg #(.Width(Width)) u_fix_rem (
    .neg(a_neg_q), .din(acc_q[2*Width-1:Width]), .dout_c(rem_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides start in IDLE/DONE and aborts CALC/FIX
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = S_CALC;
      S_CALC: begin
        if (bus.flush)                          state_d = S_IDLE;
        else if (cnt_q == CntW'(Width - 1))     state_d = S_FIX;
      end
      S_FIX:  state_d = bus.flush ? S_IDLE : S_DONE;
      S_DONE: state_d = accept_c ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, taken from the next state so registered outputs track the state
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    wb_load_c = 1'b0;
    busy_d    = (state_d == S_CALC) || (state_d == S_FIX);
    done_d    = (state_d == S_DONE);
    wb_en_d   = done_d && (rd_q != 5'd0);
    wb_load_c = done_d;
  end

  // One iteration: multiply keeps {hi, multiplier}, divide keeps {remainder, dividend}
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opnd_q} : {(Width+1){1'b0}});
    div_shift_c = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    if (f3_q[2]) begin
      if (!div_diff_c[Width]) acc_step_c = {div_diff_c[Width-1:0], acc_q[Width-2:0], 1'b1};
      else                    acc_step_c = {div_shift_c[Width-1:0], acc_q[Width-2:0], 1'b0};
    end else begin
      acc_step_c = {mul_sum_c, acc_q[Width-1:1]};
    end
  end

  // Result select in FIX; divide-by-zero forces an all-ones quotient for either sign
  always_comb begin
    result_c = '0;
    case (f3_q)
      F3_MUL:                       result_c = prod_c[Width-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_c = prod_c[2*Width-1:Width];
      F3_DIV, F3_DIVU:              result_c = dz_q ? {Width{1'b1}} : quo_c;
      F3_REM, F3_REMU:              result_c = rem_c;
      default:                      result_c = '0;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
    end else if (accept_c) begin
      cnt_q   <= '0;
      f3_q    <= bus.funct3;
      rd_q    <= bus.rd_in;
      a_neg_q <= a_neg_c;
      b_neg_q <= b_neg_c;
      dz_q    <= (bus.op_b == '0);
      opnd_q  <= bus.funct3[2] ? b_mag_c : a_mag_c;
      acc_q   <= bus.funct3[2] ? {{Width{1'b0}}, a_mag_c} : {{Width{1'b0}}, b_mag_c};
    end else if (state_q == S_CALC) begin
      cnt_q   <= cnt_q + CntW'(1);
      acc_q   <= acc_step_c;
    end
  end

  // Registered outputs; write-back data holds until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wb_en   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.busy  <= busy_d;
      bus.done  <= done_d;
      bus.wb_en <= wb_en_d;
      if (wb_load_c) begin
        bus.wb_addr <= rd_q;
        bus.wb_data <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against
// an arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int LAT = 34;
  localparam int MAX_WAIT = 60;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_if #(.Width(32)) bus ();
  muldiv_unit #(.Width(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      F3_MUL:    begin p = ua * ub; r = p[31:0]; end
      F3_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
      F3_MULHU:  begin p = ua * ub; r = p[63:32]; end
      F3_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin q = sa / sb; r = 32'(q); end
      end
      F3_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin q = sa % sb; r = 32'(q); end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = 32'd0;
      1:       r = 32'd1;
      2:       r = 32'hFFFF_FFFF;
      3:       r = 32'h8000_0000;
      4:       r = 32'h7FFF_FFFF;
      default: r = $urandom();
    endcase
    return r;
  endfunction

  // Entered and left on a negedge; cyc counts edges from the start edge (which is 1)
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int cyc);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom());
    bus.op_a   = $urandom();
    bus.op_b   = $urandom();
    bus.rd_in  = 5'($urandom());
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < MAX_WAIT) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input int cyc, input logic [31:0] exp,
                          input logic [4:0] rd);
    chk({name, " latency"}, 32'(cyc), 32'(LAT));
    chk({name, " done"}, 32'(bus.done), 32'd1);
    chk({name, " data"}, bus.wb_data, exp);
    chk({name, " wb_en"}, 32'(bus.wb_en), 32'(rd != 5'd0));
    chk({name, " wb_addr"}, 32'(bus.wb_addr), 32'(rd));
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, " busy"}, 32'(bus.busy), 32'd0);
    chk({name, " done"}, 32'(bus.done), 32'd0);
    chk({name, " wb_en"}, 32'(bus.wb_en), 32'd0);
    chk({name, " wb_addr"}, 32'(bus.wb_addr), 32'd0);
    chk({name, " wb_data"}, bus.wb_data, 32'd0);
  endtask

  vec_t        vecs[15];
  int          cyc;
  logic [2:0]  f3;
  logic [31:0] a, b, exp, last_data;
  logic [4:0]  rd;
  int          seen;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{F3_MUL,    32'd7,          32'd6,          5'd5,  32'h0000_002A};
    vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000};
    vecs[2]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd2,  32'hFFFF_FFFF};
    vecs[3]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFE};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{F3_DIVU,   32'hFFFF_FFF9,  32'd2,          5'd7,  32'h7FFF_FFFC};
    vecs[7]  = '{F3_DIV,    32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF};
    vecs[8]  = '{F3_REMU,   32'd5,          32'd0,          5'd9,  32'd5};
    vecs[9]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000};
    vecs[10] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0};
    vecs[11] = '{F3_MUL,    32'd3,          32'd4,          5'd0,  32'd12};
    vecs[12] = '{F3_DIV,    32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFF};
    vecs[13] = '{F3_REM,    32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFB};
    vecs[14] = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 32'd0};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, cyc);
      wait_done(cyc);
      check_op($sformatf("vec%0d", i), cyc, vecs[i].exp, vecs[i].rd);
    end

    // start while busy is ignored, then a back-to-back start from the DONE cycle
    launch(F3_MUL, 32'd7, 32'd6, 5'd5, cyc);
    repeat (3) begin @(posedge clk); cyc++; @(negedge clk); end
    bus.start  = 1'b1;
    bus.funct3 = F3_DIV;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd3;
    bus.rd_in  = 5'd9;
    @(posedge clk); cyc++;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    check_op("busy_start", cyc, 32'h2A, 5'd5);
    launch(F3_DIVU, 32'd100, 32'd7, 5'd3, cyc);
    chk("b2b done low", 32'(bus.done), 32'd0);
    chk("b2b busy", 32'(bus.busy), 32'd1);
    wait_done(cyc);
    check_op("b2b", cyc, 32'd14, 5'd3);

    // Random operations against the reference model
    last_data = 32'd14;
    for (int i = 0; i < 150; i++) begin
      f3  = 3'($urandom());
      a   = pick_operand();
      b   = pick_operand();
      rd  = 5'($urandom_range(0, 31));
      exp = ref_model(f3, a, b);
      launch(f3, a, b, rd, cyc);
      wait_done(cyc);
      check_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, f3, a, b), cyc, exp, rd);
      last_data = exp;
    end

    // flush together with start in DONE: flush wins
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd2;
    bus.op_b   = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start busy", 32'(bus.busy), 32'd0);
    chk("flush_start done", 32'(bus.done), 32'd0);
    chk("flush_start data", bus.wb_data, last_data);

    // flush at CALC cycle 10
    launch(F3_MUL, 32'd3, 32'd5, 5'd7, cyc);
    while (cyc < 10) begin @(posedge clk); cyc++; @(negedge clk); end
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.wb_en) seen = 1;
    end
    chk("flush no done", 32'(seen), 32'd0);
    chk("flush data", bus.wb_data, last_data);

    // async reset mid-CALC, then a fresh op
    launch(F3_MUL, 32'd9, 32'd9, 5'd4, cyc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(F3_MUL, 32'd3, 32'd3, 5'd2, cyc);
    wait_done(cyc);
    check_op("post_reset", cyc, 32'd9, 5'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
